// File: rtl/sparc_pkg.sv
// sparc_pkg: shared register-file widths and the constant zero word.
package sparc_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NUM_REGS = 32;
   localparam logic [31:0] ZERO_WORD = 32'h0;
endpackage

// File: rtl/decoder_5x32.sv
// decoder_5x32: enabled one-hot write-address decoder; output 0 is tied low so R0 never loads.
module decoder_5x32 #(
   parameter int A = 5,
   parameter int N = 32
) (
   input  logic         en,
   input  logic [A-1:0] addr,
   output logic [N-1:0] sel
);
   always_comb begin
      sel = '0;
      sel[addr] = en;
      sel[0] = 1'b0;
   end
endmodule

// File: rtl/mux_32x1_32bit.sv
// mux_32x1_32bit: selects one word out of a flattened bank of N words.
module mux_32x1_32bit #(
   parameter int W = 32,
   parameter int A = 5,
   parameter int N = 32
) (
   input  logic [N*W-1:0] r,
   input  logic [A-1:0]   sel,
   output logic [W-1:0]   y
);
   always_comb y = r[sel*W +: W];
endmodule

// File: rtl/register_32bit.sv
// register_32bit: word register with load enable and asynchronous active-low clear.
module register_32bit
   import sparc_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= W'(ZERO_WORD);
      else if (load) q <= d;
endmodule

// File: rtl/register_file_3r1w.sv
// register_file_3r1w: 32x32 register file, three combinational reads, one synchronous write, R0 = 0.
// Optional write-through bypass on each read port when RF_BYPASS_EN is defined.
module register_file_3r1w #(
   parameter int DATA_W = sparc_pkg::DATA_W,
   parameter int ADDR_W = sparc_pkg::ADDR_W,
   parameter int NUM_REGS = sparc_pkg::NUM_REGS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] rw,
   input  logic [DATA_W-1:0] pw,
   input  logic [ADDR_W-1:0] ra,
   input  logic [ADDR_W-1:0] rb,
   input  logic [ADDR_W-1:0] rd,
   output logic [DATA_W-1:0] pa,
   output logic [DATA_W-1:0] pb,
   output logic [DATA_W-1:0] pd
);
   import sparc_pkg::*;
   logic [NUM_REGS-1:0] sel;
   logic [NUM_REGS*DATA_W-1:0] regs;
   logic [DATA_W-1:0] ma, mb, md;
   decoder_5x32 #(.A(ADDR_W), .N(NUM_REGS)) u_dec (.en(we), .addr(rw), .sel(sel));
   assign regs[DATA_W-1:0] = DATA_W'(ZERO_WORD);
   for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
      register_32bit #(.W(DATA_W)) u_reg (
         .clk(clk), .rst_n(rst_n), .load(sel[g]), .d(pw), .q(regs[g*DATA_W +: DATA_W])
      );
   end
   mux_32x1_32bit #(.W(DATA_W), .A(ADDR_W), .N(NUM_REGS)) u_mux_a (.r(regs), .sel(ra), .y(ma));
   mux_32x1_32bit #(.W(DATA_W), .A(ADDR_W), .N(NUM_REGS)) u_mux_b (.r(regs), .sel(rb), .y(mb));
   mux_32x1_32bit #(.W(DATA_W), .A(ADDR_W), .N(NUM_REGS)) u_mux_d (.r(regs), .sel(rd), .y(md));
`ifdef RF_BYPASS_EN
   // Forward write data only for a live, non-R0 write outside reset.
   logic byp;
   assign byp = we && rst_n && (rw != '0);
   assign pa = (byp && ra == rw) ? pw : ma;
   assign pb = (byp && rb == rw) ? pw : mb;
   assign pd = (byp && rd == rw) ? pw : md;
`else
   assign pa = ma;
   assign pb = mb;
   assign pd = md;
`endif
endmodule

// File: tb/tb_register_file_3r1w.sv
// tb_register_file_3r1w: directed vectors with queued expectations checked by a negedge monitor.
module tb_register_file_3r1w;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic we = 1'b0;
   logic [4:0] rw = '0, ra = '0, rb = '0, rd = '0;
   logic [31:0] pw = '0;
   logic [31:0] pa, pb, pd;
   int checks = 0;
   int errors = 0;

   typedef struct {
      string name;
      logic [31:0] ea;
      logic [31:0] eb;
      logic [31:0] ed;
   } exp_t;
   exp_t q[$];
   exp_t e;

   register_file_3r1w dut (
      .clk(clk), .rst_n(rst_n), .we(we), .rw(rw), .pw(pw),
      .ra(ra), .rb(rb), .rd(rd), .pa(pa), .pb(pb), .pd(pd)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string n, input string p, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s port %s got %h expected %h", n, p, act, exp_v);
      end
   endtask

   always @(negedge clk)
      if (q.size() > 0) begin
         e = q.pop_front();
         cmp(e.name, "a", pa, e.ea);
         cmp(e.name, "b", pb, e.eb);
         cmp(e.name, "d", pd, e.ed);
      end

   // Drive one cycle just after the rising edge; an optional expectation is checked at the following negedge.
   task automatic cyc(input string n, input logic r, input logic w, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input bit chk, input logic [31:0] ea,
                      input logic [31:0] eb, input logic [31:0] ed);
      exp_t x;
      @(posedge clk);
      #1;
      rst_n = r; we = w; rw = wa; pw = wd; ra = a; rb = b; rd = d;
      if (chk) begin
         x.name = n; x.ea = ea; x.eb = eb; x.ed = ed;
         q.push_back(x);
      end
   endtask

   function automatic logic [31:0] sweep_val(input int n);
      return 32'(n) * 32'h01010101;
   endfunction

   logic [31:0] coll_pre;

   initial begin
`ifdef RF_BYPASS_EN
      coll_pre = 32'h22;
`else
      coll_pre = 32'h11;
`endif
      cyc("rst_state", 0, 0, 0, 0, 1, 15, 31, 1, 0, 0, 0);
      cyc("rst_wr_ovr", 0, 1, 5, 32'hDEADBEEF, 5, 5, 5, 1, 0, 0, 0);
      cyc("first_wr", 1, 1, 7, 32'h12345678, 5, 6, 8, 1, 0, 0, 0);
      cyc("wr_rd", 1, 0, 0, 0, 7, 6, 8, 1, 32'h12345678, 0, 0);
      cyc("r0_wr_pre", 1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0);
      cyc("r0_wr", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      cyc("dis_wr_pre", 1, 0, 3, 32'hA5A5A5A5, 3, 3, 3, 1, 0, 0, 0);
      cyc("dis_wr", 1, 0, 0, 0, 3, 3, 7, 1, 0, 0, 32'h12345678);
      cyc("r5_wr", 1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
      cyc("r5_rd", 1, 0, 0, 0, 5, 5, 5, 1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
      cyc("async_rst", 0, 0, 0, 0, 5, 5, 5, 1, 0, 0, 0);
      cyc("rst_ovr", 0, 1, 5, 32'hCAFEF00D, 5, 7, 3, 1, 0, 0, 0);
      cyc("post_rst", 1, 0, 0, 0, 5, 7, 3, 1, 0, 0, 0);
      cyc("coll_setup", 1, 1, 9, 32'h11, 0, 0, 0, 0, 0, 0, 0);
      cyc("coll_pre", 1, 1, 9, 32'h22, 9, 9, 9, 1, coll_pre, coll_pre, coll_pre);
      cyc("coll_post", 1, 0, 0, 0, 9, 9, 9, 1, 32'h22, 32'h22, 32'h22);
      for (int n = 1; n < 32; n++)
         cyc("sweep_wr", 1, 1, 5'(n), sweep_val(n), 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 32; i++)
         cyc($sformatf("sweep_rd%0d", i), 1, 0, 0, 0, 5'(i), 5'((i + 7) % 32), 5'(31 - i), 1,
             sweep_val(i), sweep_val((i + 7) % 32), sweep_val(31 - i));
      @(negedge clk);
      #1;
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending %0d expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
